// File: rtl/lc3_run_controller.sv
// Run/step/halt controller for the LC-3 core: gates the CPU clock enable and
// freezes the core on the halt state, a breakpoint fetch or an exhausted cycle budget.
module lc3_run_controller #(
  parameter int unsigned          STATE_W     = 6,
  parameter logic [STATE_W-1:0]   HALT_STATE  = 6'b100100,
  parameter logic [STATE_W-1:0]   FETCH_STATE = 6'b010010,
  parameter int unsigned          ADDR_W      = 16,
  parameter int unsigned          NUM_BP      = 2,
  parameter int unsigned          CNT_W       = 32,
  localparam int unsigned         BPI_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_run,
  input  logic                       cmd_step,
  input  logic                       cmd_halt,
  input  logic                       cmd_clear,
  input  logic [CNT_W-1:0]           timeout_limit,
  input  logic [NUM_BP*ADDR_W-1:0]   bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  input  logic [STATE_W-1:0]         cpu_state,
  input  logic [ADDR_W-1:0]          cpu_pc,
  output logic                       cpu_ce,
  output logic [1:0]                 run_state,
  output logic                       halted,
  output logic                       bp_hit,
  output logic                       timeout,
  output logic [BPI_W-1:0]           bp_index,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           instr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    STEP    = 2'b10,
    STOPPED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               first_cyc_q, first_cyc_d;
  logic               halted_q, halted_d;
  logic               bp_hit_q, bp_hit_d;
  logic               timeout_q, timeout_d;
  logic [BPI_W-1:0]   bp_index_q, bp_index_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instr_q, instr_d;

  logic               bp_match_s;
  logic [BPI_W-1:0]   bp_sel_s;
  logic               active_s;
  logic               at_fetch_s;
  logic               halt_cond_s;
  logic               bp_cond_s;
  logic               to_cond_s;
  logic               step_done_s;
  logic               stop_s;

  // Lowest-numbered enabled channel matching the PC wins.
  always_comb begin
    bp_match_s = 1'b0;
    bp_sel_s   = {BPI_W{1'b0}};
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (cpu_pc == bp_addr[i*ADDR_W +: ADDR_W])) begin
        bp_match_s = 1'b1;
        bp_sel_s   = BPI_W'(i);
      end else begin
        bp_match_s = bp_match_s;
      end
    end
  end

  assign active_s    = (state_q == RUN) || (state_q == STEP);
  assign at_fetch_s  = (cpu_state == FETCH_STATE);
  assign halt_cond_s = (cpu_state == HALT_STATE);
  assign bp_cond_s   = !first_cyc_q && at_fetch_s && bp_match_s;
  assign to_cond_s   = (timeout_limit != {CNT_W{1'b0}}) && (cycle_q >= timeout_limit);
  assign step_done_s = (state_q == STEP) && !first_cyc_q && at_fetch_s;
  assign stop_s      = active_s &&
                       (halt_cond_s || bp_cond_s || to_cond_s || cmd_halt || step_done_s);
  // The enable is combinational so the core freezes in the very cycle a stop is seen.
  assign cpu_ce      = active_s && !stop_s;

  // Next-state, stop-cause capture, command handling and counter update.
  always_comb begin
    state_d     = state_q;
    first_cyc_d = 1'b0;
    halted_d    = halted_q;
    bp_hit_d    = bp_hit_q;
    timeout_d   = timeout_q;
    bp_index_d  = bp_index_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;

    if (cpu_ce && (cycle_q != CNT_MAX)) begin
      cycle_d = cycle_q + CNT_ONE;
    end else begin
      cycle_d = cycle_q;
    end
    if (cpu_ce && at_fetch_s && (instr_q != CNT_MAX)) begin
      instr_d = instr_q + CNT_ONE;
    end else begin
      instr_d = instr_q;
    end

    case (state_q)
      RUN, STEP: begin
        if (stop_s) begin
          state_d = STOPPED;
          if (halt_cond_s) begin
            halted_d = 1'b1;
          end else if (bp_cond_s) begin
            bp_hit_d   = 1'b1;
            bp_index_d = bp_sel_s;
          end else if (to_cond_s) begin
            timeout_d = 1'b1;
          end else begin
            halted_d = halted_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      IDLE, STOPPED: begin
        if (cmd_clear) begin
          cycle_d   = {CNT_W{1'b0}};
          instr_d   = {CNT_W{1'b0}};
          halted_d  = 1'b0;
          bp_hit_d  = 1'b0;
          timeout_d = 1'b0;
        end else begin
          cycle_d = cycle_d;
        end
        // A halt pulse here outranks run/step and simply leaves the state alone.
        if (cmd_halt) begin
          state_d = state_q;
        end else if (cmd_run || cmd_step) begin
          state_d     = cmd_run ? RUN : STEP;
          first_cyc_d = 1'b1;
          halted_d    = 1'b0;
          bp_hit_d    = 1'b0;
          timeout_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      first_cyc_q <= 1'b0;
      halted_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      timeout_q   <= 1'b0;
      bp_index_q  <= {BPI_W{1'b0}};
      cycle_q     <= {CNT_W{1'b0}};
      instr_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      first_cyc_q <= first_cyc_d;
      halted_q    <= halted_d;
      bp_hit_q    <= bp_hit_d;
      timeout_q   <= timeout_d;
      bp_index_q  <= bp_index_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
    end
  end

  assign run_state   = state_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign timeout     = timeout_q;
  assign bp_index    = bp_index_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_lc3_run_controller.sv
// Directed bench for lc3_run_controller driving a tiny 4-cycle-per-instruction CPU model.
module tb_lc3_run_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_clear = 1'b0;
  logic [31:0] timeout_limit = 32'd0;
  logic [31:0] bp_addr = 32'd0;
  logic [1:0]  bp_en = 2'b00;
  logic [5:0]  cpu_state;
  logic [15:0] cpu_pc;
  logic        cpu_ce;
  logic [1:0]  run_state;
  logic        halted, bp_hit, timeout;
  logic [0:0]  bp_index;
  logic [31:0] cycle_count, instr_count;

  int checks = 0;
  int failures = 0;

  lc3_run_controller dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_clear(cmd_clear),
    .timeout_limit(timeout_limit), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_state(cpu_state), .cpu_pc(cpu_pc), .cpu_ce(cpu_ce), .run_state(run_state),
    .halted(halted), .bp_hit(bp_hit), .timeout(timeout), .bp_index(bp_index),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // CPU model: phases 18,33,35,32 per instruction; PC advances at end unless looping.
  logic [15:0] m_pc = 16'h3000;
  logic [1:0]  m_phase = 2'd0;
  int          m_done = 0;
  int          m_halt_after = 0;
  logic        m_loop = 1'b0;
  logic        m_halted = 1'b0;
  int          ce_cnt = 0;
  logic        ld_req = 1'b0;
  logic [15:0] ld_pc = 16'h3000;
  int          ld_halt_after = 0;
  logic        ld_loop = 1'b0;
  logic        ld_halted = 1'b0;

  always @(posedge clk) begin
    if (ld_req) begin
      m_pc <= ld_pc; m_phase <= 2'd0; m_done <= 0; m_halt_after <= ld_halt_after;
      m_loop <= ld_loop; m_halted <= ld_halted; ce_cnt <= 0;
    end else if (cpu_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (m_phase == 2'd3) begin
        m_phase <= 2'd0;
        m_done  <= m_done + 1;
        if (!m_loop) m_pc <= m_pc + 16'd1;
        if (m_halt_after != 0 && m_done + 1 == m_halt_after) m_halted <= 1'b1;
      end else begin
        m_phase <= m_phase + 2'd1;
      end
    end
  end

  always_comb begin
    cpu_pc = m_pc;
    if (m_halted) cpu_state = 6'd36;
    else begin
      case (m_phase)
        2'd0: cpu_state = 6'd18;
        2'd1: cpu_state = 6'd33;
        2'd2: cpu_state = 6'd35;
        default: cpu_state = 6'd32;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command pulses are raised just after a falling edge; this retires them after one rising edge.
  task automatic edge_release();
    @(posedge clk); #1;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cmd_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [15:0] pc, input int halt_after, input logic loop, input logic hlt);
    ld_pc = pc; ld_halt_after = halt_after; ld_loop = loop; ld_halted = hlt; ld_req = 1'b1;
    @(posedge clk); #1; ld_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_stop(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (run_state == 2'b11) break;
      @(negedge clk);
    end
    check(tag, 64'(run_state), 64'd3);
  endtask

  initial begin
    load(16'h3000, 10, 1'b0, 1'b0);
    check("rst_ce", 64'(cpu_ce), 64'd0);
    check("rst_state_async", 64'(run_state), 64'd0);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    check("rst_state", 64'(run_state), 64'd0);
    check("rst_flags", 64'({halted, bp_hit, timeout}), 64'd0);
    check("rst_bp_index", 64'(bp_index), 64'd0);
    check("rst_cycles", 64'(cycle_count), 64'd0);
    check("rst_instrs", 64'(instr_count), 64'd0);

    cmd_run = 1'b1; cmd_halt = 1'b1; edge_release();
    check("run_halt_idle_state", 64'(run_state), 64'd0);
    check("run_halt_idle_ce", 64'(cpu_ce), 64'd0);

    // Program halts after 10 instructions = 40 ce cycles.
    cmd_run = 1'b1; edge_release();
    check("run_started", 64'(run_state), 64'd1);
    check("run_ce_high", 64'(cpu_ce), 64'd1);
    for (int n = 0; n < 200; n++) begin
      if (cpu_state == 6'd36) break;
      @(negedge clk);
    end
    check("halt_seen", 64'(cpu_state), 64'd36);
    check("halt_ce_same_cycle", 64'(cpu_ce), 64'd0);
    check("halt_state_before_edge", 64'(run_state), 64'd1);
    @(negedge clk);
    check("halt_state", 64'(run_state), 64'd3);
    check("halt_flag", 64'({halted, bp_hit, timeout}), 64'b100);
    check("halt_cycles", 64'(cycle_count), 64'd40);
    check("halt_instrs", 64'(instr_count), 64'd10);

    cmd_clear = 1'b1; edge_release();
    check("clear_cycles", 64'(cycle_count), 64'd0);
    check("clear_instrs", 64'(instr_count), 64'd0);
    check("clear_halted", 64'(halted), 64'd0);
    check("clear_state", 64'(run_state), 64'd3);

    // Breakpoint on channel 0 at 3004.
    load(16'h3000, 0, 1'b0, 1'b0);
    bp_addr = {16'h3006, 16'h3004}; bp_en = 2'b01;
    cmd_run = 1'b1; edge_release();
    wait_stop("bp0_stopped", 100);
    check("bp0_pc", 64'(cpu_pc), 64'h3004);
    check("bp0_hit", 64'({halted, bp_hit, timeout}), 64'b010);
    check("bp0_index", 64'(bp_index), 64'd0);
    check("bp0_instrs", 64'(instr_count), 64'd4);
    check("bp0_cycles", 64'(cycle_count), 64'd16);

    // Resume must pass 3004 and trap on channel 1 at 3006.
    bp_en = 2'b11;
    cmd_run = 1'b1; edge_release();
    check("resume_running", 64'(run_state), 64'd1);
    wait_stop("bp1_stopped", 100);
    check("bp1_pc", 64'(cpu_pc), 64'h3006);
    check("bp1_index", 64'(bp_index), 64'd1);
    check("bp1_hit", 64'(bp_hit), 64'd1);
    check("bp1_instrs", 64'(instr_count), 64'd6);
    check("bp1_cycles", 64'(cycle_count), 64'd24);

    cmd_step = 1'b1; edge_release();
    check("step_state", 64'(run_state), 64'd2);
    check("step_ce", 64'(cpu_ce), 64'd1);
    wait_stop("step_stopped", 50);
    check("step_pc", 64'(cpu_pc), 64'h3007);
    check("step_instrs", 64'(instr_count), 64'd7);
    check("step_cycles", 64'(cycle_count), 64'd28);
    check("step_flags", 64'({halted, bp_hit, timeout}), 64'd0);

    cmd_run = 1'b1; edge_release();
    @(negedge clk);
    cmd_halt = 1'b1; #1;
    check("cmdhalt_ce_same_cycle", 64'(cpu_ce), 64'd0);
    edge_release();
    check("cmdhalt_state", 64'(run_state), 64'd3);
    check("cmdhalt_flags", 64'({halted, bp_hit, timeout}), 64'd0);

    // Self-looping program with a 25-cycle budget.
    cmd_clear = 1'b1; edge_release();
    load(16'h4000, 0, 1'b1, 1'b0);
    bp_en = 2'b00; timeout_limit = 32'd25;
    cmd_run = 1'b1; edge_release();
    wait_stop("to_stopped", 200);
    check("to_ce_cycles", 64'(ce_cnt), 64'd25);
    check("to_flag", 64'({halted, bp_hit, timeout}), 64'b001);
    check("to_cycles", 64'(cycle_count), 64'd25);
    check("to_instrs", 64'(instr_count), 64'd7);
    timeout_limit = 32'd0;

    cmd_clear = 1'b1; edge_release();
    load(16'h3000, 0, 1'b0, 1'b1);
    cmd_run = 1'b1; edge_release();
    check("from_halt_state", 64'(run_state), 64'd1);
    check("from_halt_ce", 64'(cpu_ce), 64'd0);
    @(negedge clk);
    check("from_halt_stopped", 64'(run_state), 64'd3);
    check("from_halt_flag", 64'(halted), 64'd1);
    check("from_halt_cycles", 64'(cycle_count), 64'd0);

    load(16'h5000, 0, 1'b1, 1'b0);
    cmd_run = 1'b1; edge_release();
    @(negedge clk);
    check("midrun_ce", 64'(cpu_ce), 64'd1);
    #2 reset_n = 1'b0; #1;
    check("midrun_rst_ce", 64'(cpu_ce), 64'd0);
    check("midrun_rst_state", 64'(run_state), 64'd0);
    check("midrun_rst_flags", 64'({halted, bp_hit, timeout, bp_index}), 64'd0);
    check("midrun_rst_cycles", 64'(cycle_count), 64'd0);
    check("midrun_rst_instrs", 64'(instr_count), 64'd0);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    check("post_rst_state", 64'(run_state), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
